// File: rtl/cpu_mem_bridge_pkg.sv
// Shared encodings for the CPU-to-RAM bridge: one-hot FSM states, request source flags and
// the wait-counter sizing.
package cpu_mem_bridge_pkg;

    typedef enum logic [4:0] {
        StIdle = 5'b00001,
        StMem  = 5'b00010,
        StCap  = 5'b00100,
        StWait = 5'b01000,
        StResp = 5'b10000
    } bridge_state_e;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned WAIT_W   = 4;

    // Saturate the configured stall so an oversized parameter cannot wrap the counter.
    function automatic logic [WAIT_W-1:0] wait_load_val(input int unsigned cycles);
        return (cycles > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : WAIT_W'(cycles);
    endfunction

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// Core-side instruction/data channels, RAM port and perf counters of the bridge.
// The bridge takes the slave view; the core/RAM environment takes the master view.
interface cpu_mem_bridge_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [31:0]       PC;
    logic              Inst_Req_Valid;
    logic              Inst_Req_Ack;
    logic [31:0]       Instruction;
    logic              Inst_Valid;
    logic              Inst_Ack;
    logic [31:0]       Address;
    logic              MemWrite;
    logic [31:0]       Write_data;
    logic [3:0]        Write_strb;
    logic              MemRead;
    logic              Mem_Req_Ack;
    logic [31:0]       Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ack;
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       cnt_inst;
    logic [31:0]       cnt_data;

    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ack, Address, MemWrite, Write_data, Write_strb,
               MemRead, Read_data_Ack, mem_rdata,
        output Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data, Read_data_Valid,
               mem_en, mem_wen, mem_addr, mem_wdata, cnt_inst, cnt_data
    );

    modport master (
        output PC, Inst_Req_Valid, Inst_Ack, Address, MemWrite, Write_data, Write_strb,
               MemRead, Read_data_Ack, mem_rdata,
        input  Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data, Read_data_Valid,
               mem_en, mem_wen, mem_addr, mem_wdata, cnt_inst, cnt_data
    );

endinterface

// File: rtl/bridge_wait_ctr.sv
// Loadable down-counter that times the artificial read-response stall.
// done_o flags the last stall cycle so the FSM can leave WAIT on it.
module bridge_wait_ctr
    import cpu_mem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              done_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/cpu_mem_bridge.sv
// Arbitrates the core's fetch and load/store channels onto one single-port synchronous RAM,
// with optional stall cycles before each read response and access counters for perf CSRs.
module cpu_mem_bridge
    import cpu_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic             clk,
    input logic             rst,
    cpu_mem_bridge_if.slave bus
);

    localparam logic              HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = wait_load_val(WAIT_CYCLES);

    bridge_state_e     state_q, state_d;
    logic              src_q, src_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       cnt_inst_q, cnt_inst_d;
    logic [31:0]       cnt_data_q, cnt_data_d;

    logic              inst_req_ack, mem_req_ack;
    logic              inst_valid, rd_valid;
    logic [31:0]       instruction, read_data;
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              wait_load, wait_dec, wait_done;

    // Byte offset and bits above the RAM window are deliberately ignored (address aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.PC[31:ADDR_W+2], bus.PC[1:0],
                                bus.Address[31:ADDR_W+2], bus.Address[1:0]};

    bridge_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wait_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (wait_dec),
        .done_o     (wait_done)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        is_wr_d      = is_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        rbuf_d       = rbuf_q;
        cnt_inst_d   = cnt_inst_q;
        cnt_data_d   = cnt_data_q;
        inst_req_ack = 1'b0;
        mem_req_ack  = 1'b0;
        inst_valid   = 1'b0;
        rd_valid     = 1'b0;
        instruction  = '0;
        read_data    = '0;
        mem_en       = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        wait_load    = 1'b0;
        wait_dec     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Data side wins; a combined write+read request is handled as a plain write.
                if (bus.MemWrite || bus.MemRead) begin
                    mem_req_ack = 1'b1;
                    src_d       = SRC_D;
                    is_wr_d     = bus.MemWrite;
                    addr_d      = bus.Address[ADDR_W+1:2];
                    wdata_d     = bus.Write_data;
                    strb_d      = bus.Write_strb;
                    cnt_data_d  = cnt_data_q + 32'd1;
                    state_d     = StMem;
                end else if (bus.Inst_Req_Valid) begin
                    inst_req_ack = 1'b1;
                    src_d        = SRC_I;
                    is_wr_d      = 1'b0;
                    addr_d       = bus.PC[ADDR_W+1:2];
                    wdata_d      = bus.Write_data;
                    strb_d       = bus.Write_strb;
                    cnt_inst_d   = cnt_inst_q + 32'd1;
                    state_d      = StMem;
                end
            end
            StMem: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
                if (is_wr_q) begin
                    mem_wen   = strb_q;
                    mem_wdata = wdata_q;
                    state_d   = StIdle;
                end else begin
                    state_d = StCap;
                end
            end
            StCap: begin
                rbuf_d = bus.mem_rdata;
                if (HAS_WAIT) begin
                    wait_load = 1'b1;
                    state_d   = StWait;
                end else begin
                    state_d = StResp;
                end
            end
            StWait: begin
                wait_dec = 1'b1;
                if (wait_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (src_q == SRC_I) begin
                    inst_valid  = 1'b1;
                    instruction = rbuf_q;
                    if (bus.Inst_Ack) begin
                        state_d = StIdle;
                    end
                end else begin
                    rd_valid  = 1'b1;
                    read_data = rbuf_q;
                    if (bus.Read_data_Ack) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Keep the bus quiet on the reset cycle itself: no accept and no RAM access leaks out.
        if (rst) begin
            inst_req_ack = 1'b0;
            mem_req_ack  = 1'b0;
            inst_valid   = 1'b0;
            rd_valid     = 1'b0;
            instruction  = '0;
            read_data    = '0;
            mem_en       = 1'b0;
            mem_wen      = '0;
            mem_addr     = '0;
            mem_wdata    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            src_q      <= SRC_I;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rbuf_q     <= '0;
            cnt_inst_q <= '0;
            cnt_data_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rbuf_q     <= rbuf_d;
            cnt_inst_q <= cnt_inst_d;
            cnt_data_q <= cnt_data_d;
        end
    end

    assign bus.Inst_Req_Ack    = inst_req_ack;
    assign bus.Mem_Req_Ack     = mem_req_ack;
    assign bus.Inst_Valid      = inst_valid;
    assign bus.Instruction     = instruction;
    assign bus.Read_data_Valid = rd_valid;
    assign bus.Read_data       = read_data;
    assign bus.mem_en          = mem_en;
    assign bus.mem_wen         = mem_wen;
    assign bus.mem_addr        = mem_addr;
    assign bus.mem_wdata       = mem_wdata;
    assign bus.cnt_inst        = cnt_inst_q;
    assign bus.cnt_data        = cnt_data_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: drivers push expected responses and RAM accesses into queues,
// an independent negedge monitor pops and compares them and checks accept timing rules.
module tb_cpu_mem_bridge;

    localparam int unsigned AW    = 12;
    localparam int unsigned W     = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk;
    logic rst;

    cpu_mem_bridge_if #(.ADDR_W(AW)) bus ();

    cpu_mem_bridge #(.ADDR_W(AW), .WAIT_CYCLES(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        src;
        logic [31:0] data;
        int          acc;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } mchk_t;

    resp_t       sb[$];
    mchk_t       mq[$];
    logic [31:0] ram       [DEPTH];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_ci;
    logic [31:0] model_cd;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          ack_mode = 0;
    bit          busy = 0;
    int          next_ok = 0;
    bit          seen_valid = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM seen by the bridge.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wen == 4'b0000) begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_wen[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response acks: 0 random, 1 always high, 2 held low.
    initial begin
        bus.Inst_Ack      = 1'b0;
        bus.Read_data_Ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                1:       begin bus.Inst_Ack = 1'b1; bus.Read_data_Ack = 1'b1; end
                2:       begin bus.Inst_Ack = 1'b0; bus.Read_data_Ack = 1'b0; end
                default: begin
                    bus.Inst_Ack      = 1'($urandom_range(0, 1));
                    bus.Read_data_Ack = 1'($urandom_range(0, 1));
                end
            endcase
        end
    end

    task automatic monitor_step();
        logic  dreq;
        logic  any_req;
        logic  any_ack;
        logic  vsrc;
        bit    can_accept;
        resp_t e;
        mchk_t m;
        dreq       = bus.MemWrite || bus.MemRead;
        any_req    = dreq || bus.Inst_Req_Valid;
        any_ack    = bus.Mem_Req_Ack || bus.Inst_Req_Ack;
        can_accept = !busy && (cyc >= next_ok);
        if (any_req || any_ack) begin
            chk("accept_timing", any_ack, can_accept && any_req);
            if (any_ack) begin
                chk("mem_req_ack", bus.Mem_Req_Ack, dreq);
                chk("inst_req_ack", bus.Inst_Req_Ack, !dreq && bus.Inst_Req_Valid);
                if (bus.Mem_Req_Ack && bus.MemWrite) next_ok = cyc + 2;
                else busy = 1;
            end
        end
        if (bus.Inst_Valid || bus.Read_data_Valid) begin
            chk("one_valid", bus.Inst_Valid && bus.Read_data_Valid, 1'b0);
            chk("resp_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e    = sb[0];
                vsrc = bus.Read_data_Valid;
                chk("resp_src", vsrc, e.src);
                chk("resp_data", vsrc ? bus.Read_data : bus.Instruction, e.data);
                if (!seen_valid) chk("resp_latency", cyc, e.acc + 3 + W);
                if (vsrc ? bus.Read_data_Ack : bus.Inst_Ack) begin
                    void'(sb.pop_front());
                    seen_valid = 0;
                    busy       = 0;
                    next_ok    = cyc + 1;
                end else begin
                    seen_valid = 1;
                end
            end
        end
        if (bus.mem_en) begin
            chk("mem_expected", mq.size() != 0, 1'b1);
            if (mq.size() != 0) begin
                m = mq.pop_front();
                chk("mem_cycle", cyc, m.cyc);
                chk("mem_addr", bus.mem_addr, m.addr);
                chk("mem_wen", bus.mem_wen, m.wen);
                if (m.wen != 4'b0000) chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) monitor_step();
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic do_data(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb);
        int            n;
        logic [AW-1:0] idx;
        bus.Address    = addr;
        bus.Write_data = wd;
        bus.Write_strb = strb;
        bus.MemWrite   = wr;
        bus.MemRead    = rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.Mem_Req_Ack && n < 200);
        chk("data_req_accepted", bus.Mem_Req_Ack, 1'b1);
        if (bus.Mem_Req_Ack) begin
            idx      = AW'(addr >> 2);
            model_cd = model_cd + 1;
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
                mq.push_back('{cyc: cyc + 1, addr: idx, wen: strb, wdata: wd});
            end else begin
                mq.push_back('{cyc: cyc + 1, addr: idx, wen: 4'b0000, wdata: 32'h0});
                sb.push_back('{src: 1'b1, data: model_mem[idx], acc: cyc});
            end
        end
        @(posedge clk);
        #1;
        bus.MemWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.Address    = $urandom;
        bus.Write_data = $urandom;
        bus.Write_strb = 4'($urandom);
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        int            n;
        logic [AW-1:0] idx;
        bus.PC             = pc;
        bus.Inst_Req_Valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.Inst_Req_Ack && n < 200);
        chk("fetch_req_accepted", bus.Inst_Req_Ack, 1'b1);
        if (bus.Inst_Req_Ack) begin
            idx      = AW'(pc >> 2);
            model_ci = model_ci + 1;
            mq.push_back('{cyc: cyc + 1, addr: idx, wen: 4'b0000, wdata: 32'h0});
            sb.push_back('{src: 1'b0, data: model_mem[idx], acc: cyc});
        end
        @(posedge clk);
        #1;
        bus.Inst_Req_Valid = 1'b0;
        bus.PC             = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || mq.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_responses", sb.size(), 0);
        chk("drain_mem", mq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_inst_req_ack"}, bus.Inst_Req_Ack, 1'b0);
        chk({tag, "_mem_req_ack"}, bus.Mem_Req_Ack, 1'b0);
        chk({tag, "_inst_valid"}, bus.Inst_Valid, 1'b0);
        chk({tag, "_rd_valid"}, bus.Read_data_Valid, 1'b0);
        chk({tag, "_instruction"}, bus.Instruction, 32'h0);
        chk({tag, "_read_data"}, bus.Read_data, 32'h0);
        chk({tag, "_mem_en"}, bus.mem_en, 1'b0);
        chk({tag, "_mem_wen"}, bus.mem_wen, 4'h0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 12'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_cnt_inst"}, bus.cnt_inst, 32'h0);
        chk({tag, "_cnt_data"}, bus.cnt_data, 32'h0);
    endtask

    initial begin
        int n;
        int unsigned op;
        bus.PC             = '0;
        bus.Inst_Req_Valid = 1'b0;
        bus.Address        = '0;
        bus.MemWrite       = 1'b0;
        bus.Write_data     = '0;
        bus.Write_strb     = '0;
        bus.MemRead        = 1'b0;
        model_ci           = '0;
        model_cd           = '0;
        rst                = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]       = $urandom;
            model_mem[i] = ram[i];
        end
        ram[1]          = 32'h0050_0093;
        model_mem[1]    = 32'h0050_0093;
        ram[12'h40]       = 32'h1122_3344;
        model_mem[12'h40] = 32'h1122_3344;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;

        // Fetch from PC=4 with the response ack held low for a while.
        ack_mode = 2;
        do_fetch(32'h0000_0004);
        n = 0;
        while (!bus.Inst_Valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_valid_seen", bus.Inst_Valid, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("fetch_valid_held", bus.Inst_Valid, 1'b1);
        end
        ack_mode = 1;
        @(posedge clk);
        #1;
        drain();
        chk("cnt_inst_first", bus.cnt_inst, model_ci);

        // Byte store into lane 2, then read the merged word back.
        do_data(1'b1, 1'b0, 32'h0000_0102, 32'hABAB_ABAB, 4'b0100);
        do_data(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'b0000);
        drain();

        // Load and fetch raised together: data must be served first.
        fork
            do_data(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'b0000);
            do_fetch(32'h0000_0010);
        join
        drain();
        chk("cnt_inst_arb", bus.cnt_inst, model_ci);
        chk("cnt_data_arb", bus.cnt_data, model_cd);

        // Random traffic on both channels with random response backpressure.
        ack_mode = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    op = $urandom_range(0, 9);
                    if (op < 4)      do_data(1'b1, 1'b0, $urandom, $urandom, 4'b1111);
                    else if (op < 8) do_data(1'b0, 1'b1, $urandom, $urandom, 4'($urandom));
                    else if (op < 9) do_data(1'b1, 1'b1, $urandom, $urandom, 4'($urandom));
                    else             do_data(1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk);
                        #1;
                    end
                    do_fetch($urandom);
                end
            end
        join
        drain();
        chk("cnt_inst_random", bus.cnt_inst, model_ci);
        chk("cnt_data_random", bus.cnt_data, model_cd);

        // Reset while a load sits in its stall window: the response must vanish.
        ack_mode = 1;
        do_data(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        sb.delete();
        mq.delete();
        model_ci   = '0;
        model_cd   = '0;
        busy       = 0;
        seen_valid = 0;
        next_ok    = 0;
        @(negedge clk);
        check_zero("mid_reset");
        repeat (15) @(negedge clk);
        @(posedge clk);
        #1;
        do_fetch(32'h0000_0000);
        drain();
        chk("cnt_inst_after_reset", bus.cnt_inst, model_ci);
        chk("cnt_data_after_reset", bus.cnt_data, model_cd);

        // Counter wrap and upper-address aliasing.
        force u_dut.cnt_data_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release u_dut.cnt_data_q;
        model_cd = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("cnt_data_preset", bus.cnt_data, model_cd);
        @(posedge clk);
        #1;
        do_data(1'b1, 1'b0, 32'hFFFF_0008, 32'hCAFE_F00D, 4'b1111);
        @(negedge clk);
        chk("cnt_data_wrap", bus.cnt_data, model_cd);
        @(posedge clk);
        #1;
        do_data(1'b0, 1'b1, 32'h0000_0008, 32'h0, 4'b0000);
        drain();
        chk("cnt_data_after_wrap", bus.cnt_data, model_cd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
